// File: rtl/dm_lat_ctrl.sv
// Handshaked data memory for the MEM stage: byte/half/word loads and stores, fixed LATENCY response.
// Latency: LATENCY cycles from the accept cycle to rsp_valid. Self-clears all DEPTH words after reset.
// Backpressure: one access in flight; req_ready low in INIT/WAIT/RESP; the response is held until rsp_ready.
// Optional build macro DM_TRACE_EN prints one trace line per committed, error-free store.
module dm_lat_ctrl #(
    parameter int          DEPTH     = 3072,
    parameter int          AW        = 12,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] INIT_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [31:0]   DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]    CNT_START = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, sext_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q, pc_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   mem_q [DEPTH];

    logic          commit;
    logic          use_raw;
    logic          op_we, op_sext;
    logic [1:0]    op_size;
    logic [31:0]   op_addr, op_wdata, op_pc;
    logic [31:0]   widx;
    logic          in_range, err_c;
    logic [31:0]   rd_word, lane, merged, load_val;

    // With LATENCY==1 the commit happens on the accept edge, so the live request is the operand.
    assign use_raw  = (state_q == S_IDLE);
    assign op_we    = use_raw ? req_we    : we_q;
    assign op_size  = use_raw ? req_size  : size_q;
    assign op_sext  = use_raw ? req_sext  : sext_q;
    assign op_addr  = use_raw ? req_addr  : addr_q;
    assign op_wdata = use_raw ? req_wdata : wdata_q;
    assign op_pc    = use_raw ? req_pc    : pc_q;

    // Range check on the full word index so high address bits never alias into the array.
    assign widx     = {2'b00, op_addr[31:2]};
    assign in_range = (widx < DEPTH_W);
    assign err_c    = (op_size == 2'b11)
                   || ((op_size == 2'b01) && op_addr[0])
                   || ((op_size == 2'b10) && (op_addr[1:0] != 2'b00))
                   || !in_range;
    assign rd_word  = in_range ? mem_q[op_addr[AW+1:2]] : 32'd0;
    assign lane     = rd_word >> {op_addr[1:0], 3'b000};

    // Store merge: replace only the addressed lane(s) of the current word.
    always_comb begin
        merged = rd_word;
        case (op_size)
            2'b00:   merged[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
            2'b01:   merged[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
            2'b10:   merged = op_wdata;
            default: merged = rd_word;
        endcase
    end

    // Load extraction with optional sign extension.
    always_comb begin
        load_val = rd_word;
        case (op_size)
            2'b00:   load_val = op_sext ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
            2'b01:   load_val = op_sext ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // Next-state logic, handshake outputs and commit strobe.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_INIT: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_START;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign rdata_d   = commit ? ((err_c || op_we) ? 32'd0 : load_val) : rdata_q;
    assign err_d     = commit ? err_c : err_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // State, sweep index, wait counter, latched request and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                size_q  <= req_size;
                sext_q  <= req_sext;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                pc_q    <= req_pc;
            end
        end
    end

    // Array writes: init sweep, or the merged word on an error-free committing store.
    // Reset holds the FSM in INIT, so a pending store can never reach its commit edge.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem_q[idx_q] <= INIT_DATA;
        end else if (commit && op_we && !err_c) begin
            mem_q[op_addr[AW+1:2]] <= merged;
`ifdef DM_TRACE_EN
            $display("%d@%h: *%h <= %h", $time, op_pc, {op_addr[31:2], 2'b00}, merged);
`endif
        end
    end

`ifndef DM_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^op_pc;
`endif

endmodule

// File: tb/tb_dm_lat_ctrl.sv
module tb_dm_lat_ctrl;
    localparam int NU = 4;
    localparam int DEP [NU] = '{3072, 64, 64, 64};
    localparam int AWS [NU] = '{12, 6, 6, 6};
    localparam int LAT [NU] = '{1, 3, 4, 2};
    localparam logic [31:0] INI [NU] = '{32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000};

    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

    logic        clk;
    logic        reset     [NU];
    logic        req_valid [NU];
    logic        req_ready [NU];
    logic        req_we    [NU];
    logic [1:0]  req_size  [NU];
    logic        req_sext  [NU];
    logic [31:0] req_addr  [NU];
    logic [31:0] req_wdata [NU];
    logic [31:0] req_pc    [NU];
    logic        rsp_valid [NU];
    logic        rsp_ready [NU];
    logic [31:0] rsp_rdata [NU];
    logic        rsp_err   [NU];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        dm_lat_ctrl #(
            .DEPTH(DEP[g]), .AW(AWS[g]), .LATENCY(LAT[g]), .INIT_DATA(INI[g])
        ) u_dut (
            .clk(clk), .reset(reset[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_we(req_we[g]), .req_size(req_size[g]), .req_sext(req_sext[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_pc(req_pc[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected event within bound", nm);
    endtask

    // Issue one request from a negedge; returns at the negedge where rsp_valid is first seen.
    task automatic xact(input int u, input logic we, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd  = 32'd0;
        er  = 1'b0;
        lat = -1;
        n   = 0;
        while (!req_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[u]) begin
            tmo("req_ready_wait");
        end else begin
            req_valid[u] = 1'b1;
            req_we[u]    = we;
            req_size[u]  = sz;
            req_sext[u]  = sx;
            req_addr[u]  = a;
            req_wdata[u] = wd;
            req_pc[u]    = 32'h0000_1000 + a;
            @(posedge clk);
            @(negedge clk);
            req_valid[u] = 1'b0;
            n = 1;
            while (!rsp_valid[u] && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!rsp_valid[u]) begin
                tmo("rsp_valid_wait");
            end else begin
                lat = n;
                rd  = rsp_rdata[u];
                er  = rsp_err[u];
            end
        end
    endtask

    task automatic wait_init(input int u, output int n);
        n = 0;
        while (!req_ready[u] && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic er);
        vec_t v;
        v.we = we; v.sz = sz; v.sx = sx; v.addr = a; v.wdata = wd;
        v.exp_rd = rd; v.exp_err = er;
        return v;
    endfunction

    initial begin
        vec_t        vt [$];
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        int          first [NU];
        bit          pending;
        int          acc [$];

        vt.push_back(mk(0, SW, 0, 32'h0000_0000, 32'h0,         32'h0000_0000, 0));
        vt.push_back(mk(1, SW, 0, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 0));
        vt.push_back(mk(0, SB, 1, 32'h0000_0013, 32'h0,         32'h0000_0012, 0));
        vt.push_back(mk(0, SH, 0, 32'h0000_0012, 32'h0,         32'h0000_1234, 0));
        vt.push_back(mk(1, SB, 0, 32'h0000_0011, 32'hFFFF_FFAB, 32'h0000_0000, 0));
        vt.push_back(mk(0, SW, 0, 32'h0000_0010, 32'h0,         32'h1234_AB78, 0));
        vt.push_back(mk(0, SB, 1, 32'h0000_0011, 32'h0,         32'hFFFF_FFAB, 0));
        vt.push_back(mk(0, SB, 0, 32'h0000_0011, 32'h0,         32'h0000_00AB, 0));
        vt.push_back(mk(0, SB, 0, 32'h0000_0010, 32'h0,         32'h0000_0078, 0));
        vt.push_back(mk(1, SH, 0, 32'h0000_0012, 32'hDEAD_8001, 32'h0000_0000, 0));
        vt.push_back(mk(0, SW, 0, 32'h0000_0010, 32'h0,         32'h8001_AB78, 0));
        vt.push_back(mk(0, SH, 1, 32'h0000_0012, 32'h0,         32'hFFFF_8001, 0));
        vt.push_back(mk(0, SH, 1, 32'h0000_0010, 32'h0,         32'hFFFF_AB78, 0));
        vt.push_back(mk(0, SH, 0, 32'h0000_0010, 32'h0,         32'h0000_AB78, 0));
        vt.push_back(mk(1, SW, 0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 0));
        vt.push_back(mk(1, SH, 0, 32'h0000_0021, 32'h0000_FFFF, 32'h0000_0000, 1));
        vt.push_back(mk(0, SW, 0, 32'h0000_0020, 32'h0,         32'h1122_3344, 0));
        vt.push_back(mk(0, SW, 0, 32'h0000_3000, 32'h0,         32'h0000_0000, 1));
        vt.push_back(mk(0, SX, 0, 32'h0000_0020, 32'h0,         32'h0000_0000, 1));
        vt.push_back(mk(1, SX, 0, 32'h0000_0020, 32'h0,         32'h0000_0000, 1));
        vt.push_back(mk(0, SW, 0, 32'h0000_0022, 32'h0,         32'h0000_0000, 1));
        vt.push_back(mk(0, SH, 0, 32'h0000_0023, 32'h0,         32'h0000_0000, 1));
        vt.push_back(mk(1, SB, 0, 32'h0000_0023, 32'h0000_0099, 32'h0000_0000, 0));
        vt.push_back(mk(0, SB, 1, 32'h0000_0023, 32'h0,         32'hFFFF_FF99, 0));
        vt.push_back(mk(0, SW, 0, 32'h0000_0020, 32'h0,         32'h9922_3344, 0));
        vt.push_back(mk(0, SH, 1, 32'h0000_0022, 32'h0,         32'hFFFF_9922, 0));
        vt.push_back(mk(0, SW, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1));
        vt.push_back(mk(1, SW, 0, 32'h0000_2FFC, 32'h5A5A_5A5A, 32'h0000_0000, 0));
        vt.push_back(mk(0, SW, 0, 32'h0000_2FFC, 32'h0,         32'h5A5A_5A5A, 0));
        vt.push_back(mk(0, SW, 0, 32'h0000_0000, 32'h0,         32'h0000_0000, 0));

        for (int u = 0; u < NU; u++) begin
            reset[u] = 1'b0; req_valid[u] = 1'b0; req_we[u] = 1'b0; req_size[u] = SW;
            req_sext[u] = 1'b0; req_addr[u] = 32'd0; req_wdata[u] = 32'd0; req_pc[u] = 32'd0;
            rsp_ready[u] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("rst_req_ready_%0d", u), 32'(req_ready[u]), 32'd0);
            chk($sformatf("rst_rsp_valid_%0d", u), 32'(rsp_valid[u]), 32'd0);
            chk($sformatf("rst_rsp_rdata_%0d", u), rsp_rdata[u], 32'd0);
            chk($sformatf("rst_rsp_err_%0d", u), 32'(rsp_err[u]), 32'd0);
        end

        // Sweep length: cycles from reset release until req_ready first rises.
        for (int u = 0; u < NU; u++) begin
            reset[u] = 1'b1;
            first[u] = -1;
        end
        n = 0;
        pending = 1'b1;
        while (pending && n < 5000) begin
            @(negedge clk);
            n++;
            pending = 1'b0;
            for (int u = 0; u < NU; u++) begin
                if (first[u] < 0 && req_ready[u]) first[u] = n;
                if (first[u] < 0) pending = 1'b1;
            end
        end
        for (int u = 0; u < NU; u++)
            chk($sformatf("init_cycles_%0d", u), 32'(first[u]), 32'(DEP[u]));

        // LATENCY=1 table on the full-depth instance.
        for (int i = 0; i < vt.size(); i++) begin
            xact(0, vt[i].we, vt[i].sz, vt[i].sx, vt[i].addr, vt[i].wdata, rd, er, lat);
            @(negedge clk);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
        end

        // LATENCY=3: response held under backpressure.
        xact(1, 1, SW, 0, 32'h0000_0008, 32'hA1B2_C3D4, rd, er, lat);
        @(negedge clk);
        chk("l3_sw_lat", 32'(lat), 32'd3);
        rsp_ready[1] = 1'b0;
        xact(1, 0, SW, 0, 32'h0000_0008, 32'h0, rd, er, lat);
        chk("l3_lw_lat", 32'(lat), 32'd3);
        chk("l3_lw_rdata", rd, 32'hA1B2_C3D4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("l3_hold%0d_valid", k), 32'(rsp_valid[1]), 32'd1);
            chk($sformatf("l3_hold%0d_rdata", k), rsp_rdata[1], 32'hA1B2_C3D4);
            chk($sformatf("l3_hold%0d_ready", k), 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("l3_release_valid", 32'(rsp_valid[1]), 32'd0);
        chk("l3_release_ready", 32'(req_ready[1]), 32'd1);
        // Address just past the array must not alias to word 0.
        xact(1, 1, SW, 0, 32'h0000_0100, 32'hFFFF_FFFF, rd, er, lat);
        @(negedge clk);
        chk("l3_oor_err", 32'(er), 32'd1);
        xact(1, 0, SW, 0, 32'h0000_0000, 32'h0, rd, er, lat);
        @(negedge clk);
        chk("l3_word0_rdata", rd, 32'h0000_0000);
        chk("l3_word0_err", 32'(er), 32'd0);

        // LATENCY=4: reset during RESP clears outputs immediately.
        rsp_ready[2] = 1'b0;
        xact(2, 0, SW, 0, 32'h0000_0000, 32'h0, rd, er, lat);
        chk("l4_lw_lat", 32'(lat), 32'd4);
        chk("l4_lw_initdata", rd, 32'hCAFE_F00D);
        #2 reset[2] = 1'b0;
        #1;
        chk("l4_rst_resp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("l4_rst_resp_rdata", rsp_rdata[2], 32'd0);
        chk("l4_rst_resp_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        reset[2] = 1'b1;
        rsp_ready[2] = 1'b1;
        wait_init(2, n);
        chk("l4_reinit1_cycles", 32'(n), 32'd64);

        // Reset during WAIT of a store: the store is dropped.
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = SW; req_sext[2] = 1'b0;
        req_addr[2] = 32'h0000_0004; req_wdata[2] = 32'h1357_2468;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("l4_wait_valid", 32'(rsp_valid[2]), 32'd0);
        chk("l4_wait_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        reset[2] = 1'b0;
        #1;
        chk("l4_rst_wait_valid", 32'(rsp_valid[2]), 32'd0);
        chk("l4_rst_wait_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        reset[2] = 1'b1;
        wait_init(2, n);
        chk("l4_reinit2_cycles", 32'(n), 32'd64);
        xact(2, 0, SW, 0, 32'h0000_0004, 32'h0, rd, er, lat);
        @(negedge clk);
        chk("l4_dropped_store", rd, 32'hCAFE_F00D);
        chk("l4_dropped_err", 32'(er), 32'd0);

        // LATENCY=2 with req_valid held high: one accept every 3 cycles.
        req_valid[3] = 1'b1; req_we[3] = 1'b0; req_size[3] = SW; req_addr[3] = 32'h0000_0000;
        for (int c = 0; c < 12; c++) begin
            if (req_ready[3]) acc.push_back(c);
            @(negedge clk);
        end
        req_valid[3] = 1'b0;
        chk("l2_accept_count", 32'(acc.size()), 32'd4);
        for (int i = 0; i < acc.size(); i++)
            chk($sformatf("l2_accept_slot%0d", i), 32'(acc[i]), 32'(3 * i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1);
    end

endmodule
